stage_issue_sched: RTL and testbench

- Dual-issue scheduler on the read side of the 2-deep dual-issue stage FIFO.
- Each cycle it decides whether to pop 0, 1 or 2 entries, using slot classes, intra-pair register hazards, the busy state of the shared multi-cycle MUL unit and serializing SYS ops.
- Popped entries go into a registered issue stage that feeds pipe0 (all classes) and pipe1 (ALU only).

---
 rtl/stage_issue_sched.sv | 124 ++++++++++++
 tb/tb_stage_issue_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_issue_sched.sv
// Dual-issue scheduler on the read side of the 2-deep stage FIFO: decides a 0/1/2 pop
// each cycle and registers the popped entries into the pipe0/pipe1 issue stage.
module stage_issue_sched #(
  parameter int Width      = 32,
  parameter int MulLatency = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       fifo_valid_i,
  input  logic [Width-1:0] fifo_data0_i,
  input  logic [Width-1:0] fifo_data1_i,
  output logic [1:0]       fifo_rdy_o,
  output logic [1:0]       iss_valid_o,
  output logic [Width-1:0] iss_data0_o,
  output logic [Width-1:0] iss_data1_o,
  input  logic             iss_rdy_i,
  input  logic             pipe_idle_i,
  input  logic             sys_done_i,
  output logic             mul_busy_o,
  output logic             sys_wait_o
);

  localparam int CntW = $clog2(MulLatency + 1);

  typedef enum logic [1:0] {CLS_ALU, CLS_MUL, CLS_LSU, CLS_SYS} cls_e;
  typedef enum logic {ST_RUN, ST_SYS_WAIT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       iss_valid_q, iss_valid_d;
  logic [Width-1:0] iss_data0_q, iss_data0_d;
  logic [Width-1:0] iss_data1_q, iss_data1_d;
  logic [CntW-1:0]  mul_cnt_q, mul_cnt_d;

  cls_e       cls0, cls1;
  logic [4:0] rd0, rd1, rs1_1, rs2_1;
  logic       ld, pop1, pop2, hazard, slot0_ok;

  assign cls0  = cls_e'(fifo_data0_i[1:0]);
  assign cls1  = cls_e'(fifo_data1_i[1:0]);
  assign rd0   = fifo_data0_i[6:2];
  assign rd1   = fifo_data1_i[6:2];
  assign rs1_1 = fifo_data1_i[11:7];
  assign rs2_1 = fifo_data1_i[16:12];

  assign ld = ~iss_valid_q[0] | iss_rdy_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    slot0_ok = 1'b1;
    hazard   = 1'b0;
    pop1     = 1'b0;
    pop2     = 1'b0;

    // A SYS op must find the whole machine quiet before it may leave the FIFO.
    if (cls0 == CLS_MUL) slot0_ok = (mul_cnt_q == '0);
    if (cls0 == CLS_SYS) slot0_ok = (iss_valid_q == 2'b00) && (mul_cnt_q == '0) && pipe_idle_i;

    if (rd0 != 5'd0) hazard = (rs1_1 == rd0) || (rs2_1 == rd0) || (rd1 == rd0);

    pop1 = ~rst_i && ~flush_i && (state_q == ST_RUN) && ld && fifo_valid_i[0] && slot0_ok;
    pop2 = pop1 && (fifo_valid_i == 2'b11) && (cls1 == CLS_ALU) && (cls0 != CLS_SYS) && ~hazard;
  end

  assign fifo_rdy_o = {pop2, pop1};

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_data0_d = iss_data0_q;
    iss_data1_d = iss_data1_q;
    mul_cnt_d   = mul_cnt_q;
    state_d     = state_q;

    if (ld) begin
      iss_valid_d = fifo_rdy_o;
      if (pop1) iss_data0_d = fifo_data0_i;
      if (pop2) iss_data1_d = fifo_data1_i;
    end

    if (pop1 && cls0 == CLS_MUL) mul_cnt_d = CntW'(MulLatency - 1);
    else if (mul_cnt_q != '0)    mul_cnt_d = mul_cnt_q - CntW'(1);

    unique case (state_q)
      ST_RUN:      if (pop1 && cls0 == CLS_SYS) state_d = ST_SYS_WAIT;
      ST_SYS_WAIT: if (sys_done_i) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    if (flush_i) begin
      iss_valid_d = 2'b00;
      mul_cnt_d   = '0;
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst_i) begin
      state_q     <= ST_RUN;
      iss_valid_q <= 2'b00;
      iss_data0_q <= '0;
      iss_data1_q <= '0;
      mul_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      iss_valid_q <= iss_valid_d;
      iss_data0_q <= iss_data0_d;
      iss_data1_q <= iss_data1_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  assign iss_valid_o = iss_valid_q;
  assign iss_data0_o = iss_data0_q;
  assign iss_data1_o = iss_data1_q;
  assign mul_busy_o  = (mul_cnt_q != '0);
  assign sys_wait_o  = (state_q == ST_SYS_WAIT);

  a_rdy_order:   assert property (@(posedge clk_i) disable iff (rst_i) fifo_rdy_o[1] |-> fifo_rdy_o[0]);
  a_valid_order: assert property (@(posedge clk_i) disable iff (rst_i) iss_valid_o[1] |-> iss_valid_o[0]);
  a_pipe1_alu:   assert property (@(posedge clk_i) disable iff (rst_i) iss_valid_o[1] |-> (iss_data1_o[1:0] == 2'b00));
  a_rdy_valid:   assert property (@(posedge clk_i) disable iff (rst_i) fifo_rdy_o[0] |-> fifo_valid_i[0]);

endmodule

// File: tb/tb_stage_issue_sched.sv
// Directed bench for stage_issue_sched: pairing, hazards, MUL spacing, SYS serialization,
// backpressure, flush and mid-stream reset, with hand-computed expectations.
module tb_stage_issue_sched;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic [1:0]   fifo_valid_i = 2'b00;
  logic [W-1:0] fifo_data0_i = '0;
  logic [W-1:0] fifo_data1_i = '0;
  logic [1:0]   fifo_rdy_o;
  logic [1:0]   iss_valid_o;
  logic [W-1:0] iss_data0_o;
  logic [W-1:0] iss_data1_o;
  logic         iss_rdy_i = 1'b1;
  logic         pipe_idle_i = 1'b1;
  logic         sys_done_i = 1'b0;
  logic         mul_busy_o;
  logic         sys_wait_o;

  int n_total = 0;
  int n_bad   = 0;

  stage_issue_sched #(.Width(W), .MulLatency(3)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_data0_i (fifo_data0_i),
    .fifo_data1_i (fifo_data1_i),
    .fifo_rdy_o   (fifo_rdy_o),
    .iss_valid_o  (iss_valid_o),
    .iss_data0_o  (iss_data0_o),
    .iss_data1_o  (iss_data1_o),
    .iss_rdy_i    (iss_rdy_i),
    .pipe_idle_i  (pipe_idle_i),
    .sys_done_i   (sys_done_i),
    .mul_busy_o   (mul_busy_o),
    .sys_wait_o   (sys_wait_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entry builder; the tag byte in [24:17] makes entries distinguishable.
  function automatic logic [W-1:0] ent(input logic [1:0] cls, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [7:0] tag);
    logic [W-1:0] e;
    e = '0;
    e[24:0] = {tag, rs2, rs1, rd, cls};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] fv, input logic [W-1:0] d0, input logic [W-1:0] d1);
    fifo_valid_i = fv;
    fifo_data0_i = d0;
    fifo_data1_i = d1;
    #1;
  endtask

  logic [W-1:0] a0, a1, b0, b1, sys_e, alu_e, mul_e, pa, pb, pc, pd;

  initial begin
    a0    = ent(2'd0, 5'd3, 5'd1, 5'd2, 8'h11);
    a1    = ent(2'd0, 5'd4, 5'd5, 5'd6, 8'h12);
    b0    = ent(2'd0, 5'd3, 5'd1, 5'd2, 8'h21);
    b1    = ent(2'd0, 5'd7, 5'd8, 5'd3, 8'h22);
    sys_e = ent(2'd3, 5'd0, 5'd0, 5'd0, 8'h31);
    alu_e = ent(2'd0, 5'd9, 5'd1, 5'd1, 8'h41);
    mul_e = ent(2'd1, 5'd9, 5'd1, 5'd2, 8'h51);
    pa    = ent(2'd0, 5'd10, 5'd1, 5'd2, 8'h61);
    pb    = ent(2'd0, 5'd11, 5'd3, 5'd4, 8'h62);
    pc    = ent(2'd0, 5'd12, 5'd1, 5'd2, 8'h63);
    pd    = ent(2'd0, 5'd13, 5'd5, 5'd6, 8'h64);

    // Reset state
    tick(); tick();
    drive(2'b11, a0, a1);
    check("rst_rdy", fifo_rdy_o, 2'b00);
    check("rst_valid", iss_valid_o, 2'b00);
    check("rst_data0", iss_data0_o, '0);
    check("rst_data1", iss_data1_o, '0);
    check("rst_busy", mul_busy_o, 1'b0);
    check("rst_sysw", sys_wait_o, 1'b0);
    rst_i = 1'b0;

    // Independent ALU pair
    drive(2'b11, a0, a1);
    check("pair_rdy", fifo_rdy_o, 2'b11);
    tick();
    check("pair_valid", iss_valid_o, 2'b11);
    check("pair_d0", iss_data0_o, a0);
    check("pair_d1", iss_data1_o, a1);

    // RAW split; pipe1 data must hold the older entry
    drive(2'b11, b0, b1);
    check("raw_rdy", fifo_rdy_o, 2'b01);
    tick();
    check("raw_valid", iss_valid_o, 2'b01);
    check("raw_d0", iss_data0_o, b0);
    check("raw_d1_hold", iss_data1_o, a1);
    drive(2'b01, b1, '0);
    check("raw2_rdy", fifo_rdy_o, 2'b01);
    tick();
    check("raw2_valid", iss_valid_o, 2'b01);
    check("raw2_d0", iss_data0_o, b1);

    // Pairing rules, combinational only
    drive(2'b11, a0, ent(2'd0, 5'd3, 5'd9, 5'd9, 8'h13));
    check("waw_rdy", fifo_rdy_o, 2'b01);
    drive(2'b11, ent(2'd0, 5'd0, 5'd1, 5'd2, 8'h14), ent(2'd0, 5'd5, 5'd0, 5'd0, 8'h15));
    check("rd0_zero_rdy", fifo_rdy_o, 2'b11);
    drive(2'b11, a0, ent(2'd2, 5'd4, 5'd5, 5'd6, 8'h16));
    check("lsu1_rdy", fifo_rdy_o, 2'b01);
    drive(2'b01, a0, a1);
    check("single_valid_rdy", fifo_rdy_o, 2'b01);
    drive(2'b11, mul_e, a1);
    check("mul_alu_pair_rdy", fifo_rdy_o, 2'b11);
    drive(2'b00, '0, '0);
    tick();
    check("idle_valid", iss_valid_o, 2'b00);

    // MUL spacing: pops at k = 0, 3, 6
    for (int k = 0; k < 7; k++) begin
      drive(2'b01, mul_e, '0);
      check($sformatf("mul_rdy_%0d", k), fifo_rdy_o, (k % 3 == 0) ? 2'b01 : 2'b00);
      check($sformatf("mul_busy_%0d", k), mul_busy_o, (k % 3 != 0));
      tick();
    end
    drive(2'b00, '0, '0);
    tick(); tick(); tick();
    check("mul_drained", mul_busy_o, 1'b0);

    // SYS serialization
    drive(2'b01, alu_e, '0);
    tick();
    check("sys_pre_valid", iss_valid_o, 2'b01);
    iss_rdy_i = 1'b0;
    pipe_idle_i = 1'b0;
    drive(2'b01, sys_e, '0);
    check("sys_blk_ld", fifo_rdy_o, 2'b00);
    iss_rdy_i = 1'b1;
    #1;
    check("sys_blk_valid", fifo_rdy_o, 2'b00);
    tick();
    check("sys_drain", iss_valid_o, 2'b00);
    check("sys_blk_idle", fifo_rdy_o, 2'b00);
    pipe_idle_i = 1'b1;
    #1;
    check("sys_pop", fifo_rdy_o, 2'b01);
    tick();
    check("sys_wait_set", sys_wait_o, 1'b1);
    check("sys_valid", iss_valid_o, 2'b01);
    check("sys_d0", iss_data0_o, sys_e);
    drive(2'b01, alu_e, '0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("sys_hold_%0d", k), fifo_rdy_o, 2'b00);
      tick();
    end
    check("sys_wait_still", sys_wait_o, 1'b1);
    sys_done_i = 1'b1;
    #1;
    check("sys_done_rdy", fifo_rdy_o, 2'b00);
    tick();
    sys_done_i = 1'b0;
    #1;
    check("sys_run", sys_wait_o, 1'b0);
    check("sys_after_rdy", fifo_rdy_o, 2'b01);
    tick();
    check("sys_after_d0", iss_data0_o, alu_e);

    // Backpressure
    drive(2'b11, pa, pb);
    check("bp_load_rdy", fifo_rdy_o, 2'b11);
    tick();
    iss_rdy_i = 1'b0;
    drive(2'b11, pc, pd);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_rdy_%0d", k), fifo_rdy_o, 2'b00);
      tick();
      check($sformatf("bp_valid_%0d", k), iss_valid_o, 2'b11);
      check($sformatf("bp_d0_%0d", k), iss_data0_o, pa);
      check($sformatf("bp_d1_%0d", k), iss_data1_o, pb);
    end
    iss_rdy_i = 1'b1;
    #1;
    check("bp_release_rdy", fifo_rdy_o, 2'b11);
    tick();
    check("bp_release_d0", iss_data0_o, pc);
    check("bp_release_d1", iss_data1_o, pd);

    // Flush in SYS_WAIT, together with sys_done
    drive(2'b00, '0, '0);
    tick();
    drive(2'b01, sys_e, '0);
    tick();
    check("fl_sysw", sys_wait_o, 1'b1);
    iss_rdy_i = 1'b0;
    flush_i = 1'b1;
    sys_done_i = 1'b1;
    drive(2'b01, alu_e, '0);
    check("fl_rdy", fifo_rdy_o, 2'b00);
    tick();
    flush_i = 1'b0;
    sys_done_i = 1'b0;
    #1;
    check("fl_run", sys_wait_o, 1'b0);
    check("fl_valid", iss_valid_o, 2'b00);
    check("fl_next_rdy", fifo_rdy_o, 2'b01);

    // Flush with mul_cnt = 2
    drive(2'b01, mul_e, '0);
    tick();
    check("flm_busy", mul_busy_o, 1'b1);
    flush_i = 1'b1;
    #1;
    check("flm_rdy", fifo_rdy_o, 2'b00);
    tick();
    flush_i = 1'b0;
    #1;
    check("flm_cnt", mul_busy_o, 1'b0);
    check("flm_valid", iss_valid_o, 2'b00);
    check("flm_next_rdy", fifo_rdy_o, 2'b01);

    // Reset mid-stream
    iss_rdy_i = 1'b1;
    drive(2'b11, pa, pb);
    tick();
    check("mrst_pre", iss_valid_o, 2'b11);
    rst_i = 1'b1;
    #1;
    check("mrst_rdy", fifo_rdy_o, 2'b00);
    tick();
    check("mrst_valid", iss_valid_o, 2'b00);
    check("mrst_d0", iss_data0_o, '0);
    check("mrst_d1", iss_data1_o, '0);
    check("mrst_busy", mul_busy_o, 1'b0);
    check("mrst_sysw", sys_wait_o, 1'b0);
    rst_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
